// File: rtl/ahb2apb_bridge_mp_pkg.sv
// Shared encodings for the AHB-Lite to APB4 bridge: transfer types, responses,
// sizes, the bridge state enum and the byte-strobe helper.
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WDATA  = 3'd1,
    SETUP  = 3'd2,
    ACCESS = 3'd3,
    DECERR = 3'd4,
    ERR1   = 3'd5,
    ERR2   = 3'd6
  } state_t;

  // Sizes above a word are treated as a full-word strobe.
  function automatic logic [3:0] strb_of(input logic [2:0] size, input logic [1:0] a);
    logic [3:0] s;
    case (size)
      HSIZE_BYTE: s = 4'b0001 << a;
      HSIZE_HALF: s = a[1] ? 4'b1100 : 4'b0011;
      default:    s = 4'b1111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ahb2apb_bridge_mp_if.sv
// Bus bundle for the bridge: AHB-Lite slave side and APB4 master side.
// The slave modport is the bridge's view; master is the environment's view.
interface ahb2apb_bridge_mp_if #(
    parameter int ADDR_W  = 32,
    parameter int NUM_SLV = 8
);
    import ahb_apb_pkg::*;

    logic                   hsel_i;
    logic                   hready_i;
    logic [1:0]             htrans_i;
    logic                   hwrite_i;
    logic [2:0]             hsize_i;
    logic [ADDR_W-1:0]      haddr_i;
    logic [31:0]            hwdata_i;
    logic                   hready_o;
    logic                   hresp_o;
    logic [31:0]            hrdata_o;
    logic [NUM_SLV-1:0]     psel_o;
    logic                   penable_o;
    logic                   pwrite_o;
    logic [ADDR_W-1:0]      paddr_o;
    logic [31:0]            pwdata_o;
    logic [3:0]             pstrb_o;
    logic [NUM_SLV*32-1:0]  prdata_i;
    logic [NUM_SLV-1:0]     pready_i;
    logic [NUM_SLV-1:0]     pslverr_i;
    state_t                 dbg_state;

    modport slave (
        input  hsel_i, hready_i, htrans_i, hwrite_i, hsize_i, haddr_i, hwdata_i,
        input  prdata_i, pready_i, pslverr_i,
        output hready_o, hresp_o, hrdata_o, psel_o, penable_o, pwrite_o,
        output paddr_o, pwdata_o, pstrb_o, dbg_state
    );

    modport master (
        output hsel_i, hready_i, htrans_i, hwrite_i, hsize_i, haddr_i, hwdata_i,
        output prdata_i, pready_i, pslverr_i,
        input  hready_o, hresp_o, hrdata_o, psel_o, penable_o, pwrite_o,
        input  paddr_o, pwdata_o, pstrb_o, dbg_state
    );

endinterface

// File: rtl/ahb2apb_bridge_mp_apb_slv_mux.sv
// Combinational slave steering: one-hot select for an index plus the
// matching read data / ready / error slice. Out-of-range indices select nothing.
module apb_slv_mux #(
    parameter int NUM_SLV = 8,
    parameter int SEL_W   = 3
) (
    input  logic [SEL_W-1:0]      idx_i,
    input  logic [NUM_SLV*32-1:0] prdata_i,
    input  logic [NUM_SLV-1:0]    pready_i,
    input  logic [NUM_SLV-1:0]    pslverr_i,
    output logic [NUM_SLV-1:0]    psel_o,
    output logic [31:0]           rdata_o,
    output logic                  ready_o,
    output logic                  slverr_o
);

    always_comb begin
        psel_o   = '0;
        rdata_o  = '0;
        ready_o  = 1'b0;
        slverr_o = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (idx_i == SEL_W'(i)) begin
                psel_o[i] = 1'b1;
                rdata_o   = prdata_i[i*32 +: 32];
                ready_o   = pready_i[i];
                slverr_o  = pslverr_i[i];
            end
        end
    end

endmodule

// File: rtl/ahb2apb_bridge_mp.sv
// AHB-Lite slave to APB4 master bridge fanning out to NUM_SLV peripherals,
// with wait states, slave/decode/timeout errors and fully registered outputs.
module ahb2apb_bridge_mp
    import ahb_apb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int NUM_SLV = 8,
    parameter int SEL_LSB = 12,
    parameter int TIMEOUT = 256
) (
    input logic               hclk,
    input logic               hreset,
    ahb2apb_bridge_mp_if.slave bus
);

    localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t              state_q, state_d;
    logic                hready_q, hready_d;
    logic                hresp_q, hresp_d;
    logic [31:0]         hrdata_q, hrdata_d;
    logic [NUM_SLV-1:0]  psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [31:0]         pwdata_q, pwdata_d;
    logic [3:0]          pstrb_q, pstrb_d;
    logic [SEL_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                accept, dec_err;
    logic [NUM_SLV-1:0]  sel_oh;
    logic [31:0]         slv_rdata;
    logic                slv_ready, slv_err;

    assign accept = (state_q == IDLE || state_q == ERR2) && bus.hsel_i && bus.hready_i &&
                    (bus.htrans_i == HTRANS_NONSEQ || bus.htrans_i == HTRANS_SEQ);
    // The mux is steered by the next index so psel can be registered on the accept edge.
    assign idx_d   = accept ? bus.haddr_i[SEL_LSB +: SEL_W] : idx_q;
    assign dec_err = int'(idx_d) >= NUM_SLV;

    apb_slv_mux #(.NUM_SLV(NUM_SLV), .SEL_W(SEL_W)) u_mux (
        .idx_i    (idx_d),
        .prdata_i (bus.prdata_i),
        .pready_i (bus.pready_i),
        .pslverr_i(bus.pslverr_i),
        .psel_o   (sel_oh),
        .rdata_o  (slv_rdata),
        .ready_o  (slv_ready),
        .slverr_o (slv_err)
    );

    always_comb begin
        state_d   = state_q;
        hready_d  = hready_q;
        hresp_d   = hresp_q;
        hrdata_d  = hrdata_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE, ERR2: begin
                state_d  = IDLE;
                hready_d = 1'b1;
                hresp_d  = HRESP_OKAY;
                if (accept) begin
                    paddr_d  = bus.haddr_i;
                    pwrite_d = bus.hwrite_i;
                    pstrb_d  = bus.hwrite_i ? strb_of(bus.hsize_i, bus.haddr_i[1:0]) : 4'b0000;
                    hready_d = 1'b0;
                    if (dec_err) begin
                        state_d = DECERR;
                    end else if (bus.hwrite_i) begin
                        state_d = WDATA;
                    end else begin
                        state_d = SETUP;
                        psel_d  = sel_oh;
                        cnt_d   = '0;
                    end
                end
            end
            WDATA: begin
                pwdata_d = bus.hwdata_i;
                psel_d   = sel_oh;
                cnt_d    = '0;
                state_d  = SETUP;
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                if (slv_ready) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                    if (slv_err) begin
                        state_d = ERR1;
                        hresp_d = HRESP_ERROR;
                    end else begin
                        state_d  = IDLE;
                        hready_d = 1'b1;
                        if (!pwrite_q) hrdata_d = slv_rdata;
                    end
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                    state_d   = ERR1;
                    hresp_d   = HRESP_ERROR;
                end
            end
            DECERR: begin
                state_d = ERR1;
                hresp_d = HRESP_ERROR;
            end
            ERR1: begin
                state_d  = ERR2;
                hready_d = 1'b1;
                hresp_d  = HRESP_ERROR;
            end
            default: begin
                state_d  = IDLE;
                hready_d = 1'b1;
                hresp_d  = HRESP_OKAY;
            end
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q   <= IDLE;
            hready_q  <= 1'b1;
            hresp_q   <= HRESP_OKAY;
            hrdata_q  <= '0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            hready_q  <= hready_d;
            hresp_q   <= hresp_d;
            hrdata_q  <= hrdata_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.hready_o  = hready_q;
    assign bus.hresp_o   = hresp_q;
    assign bus.hrdata_o  = hrdata_q;
    assign bus.psel_o    = psel_q;
    assign bus.penable_o = penable_q;
    assign bus.pwrite_o  = pwrite_q;
    assign bus.paddr_o   = paddr_q;
    assign bus.pwdata_o  = pwdata_q;
    assign bus.pstrb_o   = pstrb_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_ahb2apb_bridge_mp.sv
// Bench for ahb2apb_bridge_mp with six slaves (so indices 6/7 decode-error) and an
// eight-cycle access timeout; a transfer-level model predicts every outcome.
module tb_ahb2apb_bridge_mp;
    import ahb_apb_pkg::*;

    localparam int ADDR_W  = 32;
    localparam int NUM_SLV = 6;
    localparam int SEL_LSB = 12;
    localparam int TIMEOUT = 8;
    localparam int SEL_W   = 3;

    logic clk = 1'b0;
    logic rst;

    ahb2apb_bridge_mp_if #(.ADDR_W(ADDR_W), .NUM_SLV(NUM_SLV)) bus ();

    ahb2apb_bridge_mp #(
        .ADDR_W(ADDR_W), .NUM_SLV(NUM_SLV), .SEL_LSB(SEL_LSB), .TIMEOUT(TIMEOUT)
    ) dut (
        .hclk  (clk),
        .hreset(rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] mdl_rdata = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    endtask

    task automatic idle(input int n);
        bus.hsel_i   = 1'b0;
        bus.htrans_i = HTRANS_IDLE;
        repeat (n) @(negedge clk);
        chk("idle_hready", bus.hready_o, 1);
        chk("idle_hresp", bus.hresp_o, 0);
        chk("idle_psel", bus.psel_o, 0);
    endtask

    // One AHB transfer, starting at a negedge where the bridge shows hready_o high.
    // waits = pready-low ACCESS cycles the addressed slave inserts; err = pslverr with pready.
    task automatic do_xfer(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                           input logic [31:0] wdata, input int waits, input bit err,
                           input logic [31:0] rdata);
        int idx, exp_low, exp_acc, exp_setup, low, acc, setup, hresp_low;
        bit dec, timed, exp_err, psel_bad, fld_bad;
        logic [3:0] exp_strb;
        logic [NUM_SLV-1:0] exp_sel;

        idx     = int'((addr >> SEL_LSB) & ((32'd1 << SEL_W) - 1));
        dec     = idx >= NUM_SLV;
        exp_sel = '0;
        if (!dec) exp_sel[idx] = 1'b1;
        if (!wr)            exp_strb = 4'b0000;
        else if (size == 0) exp_strb = 4'b0001 << addr[1:0];
        else if (size == 1) exp_strb = addr[1] ? 4'b1100 : 4'b0011;
        else                exp_strb = 4'b1111;
        timed     = !dec && (waits >= TIMEOUT);
        exp_err   = dec || timed || err;
        exp_acc   = dec ? 0 : (timed ? TIMEOUT : waits + 1);
        exp_setup = dec ? 0 : 1;
        exp_low   = dec ? 2 : (wr ? 1 : 0) + 1 + exp_acc + (exp_err ? 1 : 0);

        chk("pre_hready", bus.hready_o, 1);
        bus.hsel_i   = 1'b1;
        bus.hready_i = 1'b1;
        bus.htrans_i = HTRANS_NONSEQ;
        bus.hwrite_i = wr;
        bus.hsize_i  = size;
        bus.haddr_i  = addr;
        for (int s = 0; s < NUM_SLV; s++) bus.prdata_i[s*32 +: 32] = $urandom;
        bus.pready_i  = NUM_SLV'($urandom);
        bus.pslverr_i = NUM_SLV'($urandom);
        if (!dec) begin
            bus.prdata_i[idx*32 +: 32] = rdata;
            bus.pready_i[idx]  = 1'b0;
            bus.pslverr_i[idx] = 1'b0;
        end

        @(negedge clk);
        bus.hsel_i   = 1'b0;
        bus.htrans_i = HTRANS_IDLE;
        bus.hwdata_i = wdata;
        low = 0; acc = 0; setup = 0; hresp_low = 0; psel_bad = 0; fld_bad = 0;
        for (int c = 0; c < 64 && bus.hready_o == 1'b0; c++) begin
            low++;
            if (bus.hresp_o) hresp_low++;
            if (bus.psel_o != '0 && bus.psel_o != exp_sel) psel_bad = 1;
            if (bus.penable_o && bus.psel_o == '0) psel_bad = 1;
            if (bus.psel_o != '0 && !bus.penable_o) begin
                setup++;
                if (bus.paddr_o != addr || bus.pwrite_o != wr || bus.pstrb_o != exp_strb ||
                    (wr && bus.pwdata_o != wdata)) fld_bad = 1;
            end
            if (!dec) begin
                if (bus.penable_o) begin
                    acc++;
                    bus.pready_i[idx]  = (acc > waits);
                    bus.pslverr_i[idx] = err && (acc > waits);
                end else begin
                    bus.pready_i[idx]  = 1'b0;
                    bus.pslverr_i[idx] = 1'b0;
                end
            end
            @(negedge clk);
        end
        if (!dec) begin
            bus.pready_i[idx]  = 1'b0;
            bus.pslverr_i[idx] = 1'b0;
        end

        if (!wr && !exp_err) mdl_rdata = rdata;
        chk("hready_rise", bus.hready_o, 1);
        chk("low_cycles", low, exp_low);
        chk("access_cycles", acc, exp_acc);
        chk("setup_cycles", setup, exp_setup);
        chk("psel_onehot", psel_bad, 0);
        chk("apb_fields", fld_bad, 0);
        chk("err1_hresp", hresp_low, exp_err ? 1 : 0);
        chk("end_hresp", bus.hresp_o, exp_err);
        chk("end_psel", bus.psel_o, 0);
        chk("end_penable", bus.penable_o, 0);
        chk("hrdata", bus.hrdata_o, mdl_rdata);
        chk("paddr_hold", bus.paddr_o, addr);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_hready"}, bus.hready_o, 1);
        chk({tag, "_hresp"}, bus.hresp_o, 0);
        chk({tag, "_hrdata"}, bus.hrdata_o, 0);
        chk({tag, "_psel"}, bus.psel_o, 0);
        chk({tag, "_penable"}, bus.penable_o, 0);
        chk({tag, "_pwrite"}, bus.pwrite_o, 0);
        chk({tag, "_paddr"}, bus.paddr_o, 0);
        chk({tag, "_pwdata"}, bus.pwdata_o, 0);
        chk({tag, "_pstrb"}, bus.pstrb_o, 0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.hsel_i    = 1'b0;
        bus.hready_i  = 1'b1;
        bus.htrans_i  = HTRANS_IDLE;
        bus.hwrite_i  = 1'b0;
        bus.hsize_i   = HSIZE_WORD;
        bus.haddr_i   = '0;
        bus.hwdata_i  = '0;
        bus.prdata_i  = '0;
        bus.pready_i  = '0;
        bus.pslverr_i = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);

        do_xfer(1'b0, 32'h0000_2004, HSIZE_WORD, 32'h0, 0, 1'b0, 32'hDEAD_BEEF);
        idle(1);
        do_xfer(1'b1, 32'h0000_1003, HSIZE_BYTE, 32'hA500_0000, 0, 1'b0, 32'h0);
        idle(1);
        do_xfer(1'b0, 32'h0000_3000, HSIZE_WORD, 32'h0, 4, 1'b0, 32'h0BAD_CAFE);
        idle(1);
        do_xfer(1'b0, 32'h0000_0010, HSIZE_WORD, 32'h0, 0, 1'b1, 32'h1111_2222);
        do_xfer(1'b0, 32'h0000_0014, HSIZE_WORD, 32'h0, 0, 1'b0, 32'h1234_5678);
        idle(1);
        do_xfer(1'b0, 32'h0000_7000, HSIZE_WORD, 32'h0, 0, 1'b0, 32'h0);
        idle(1);
        do_xfer(1'b1, 32'h0000_5008, HSIZE_HALF, 32'hCAFE_F00D, 20, 1'b0, 32'h0);
        idle(1);

        // BUSY and transfers without hready_i must be ignored.
        bus.hsel_i = 1'b1; bus.hready_i = 1'b1; bus.htrans_i = HTRANS_BUSY;
        @(negedge clk);
        chk("busy_hready", bus.hready_o, 1);
        chk("busy_psel", bus.psel_o, 0);
        bus.hready_i = 1'b0; bus.htrans_i = HTRANS_NONSEQ;
        @(negedge clk);
        chk("nordy_hready", bus.hready_o, 1);
        chk("nordy_psel", bus.psel_o, 0);
        bus.hready_i = 1'b1;
        idle(1);

        // Reset while ACCESS is waiting on a stalled slave.
        bus.hsel_i = 1'b1; bus.htrans_i = HTRANS_NONSEQ; bus.hwrite_i = 1'b0;
        bus.haddr_i = 32'h0000_3008; bus.pready_i = '0;
        @(negedge clk);
        bus.hsel_i = 1'b0; bus.htrans_i = HTRANS_IDLE;
        for (int c = 0; c < 8 && !bus.penable_o; c++) @(negedge clk);
        chk("rst_mid_access", bus.penable_o, 1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("rst_mid");
        rst = 1'b0;
        mdl_rdata = '0;
        @(negedge clk);
        do_xfer(1'b0, 32'h0000_4000, HSIZE_WORD, 32'h0, 1, 1'b0, 32'h5A5A_A5A5);

        for (int t = 0; t < 40; t++) begin
            bit          wr, err;
            logic [31:0] addr;
            wr   = 1'($urandom_range(0, 1));
            err  = ($urandom_range(0, 3) == 0);
            addr = $urandom;
            do_xfer(wr, addr, 3'($urandom_range(0, 2)), $urandom,
                    int'($urandom_range(0, 9)), err, $urandom);
            if ($urandom_range(0, 1) == 1) idle(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ahb2apb_bridge_mp.md
Name: ahb2apb_bridge_mp

Overview:
- Parametrised AHB-Lite slave to APB4 master bridge for the peripheral subsystem.
- Fans out to NUM_SLV APB slaves selected by an address-slice decode.
- Supports PREADY wait states, PSLVERR-to-HRESP error mapping, byte strobes, a decode-error path and an access timeout.
- Sits between the AHB interconnect and the APB peripheral cluster (UART, GPIO, timers).

Parameters:
- ADDR_W, 32, AHB/APB address width.
- NUM_SLV, 8, number of APB slaves (1..16).
- SEL_LSB, 12, lowest haddr bit of the slave-index slice; slice width SEL_W = clog2(NUM_SLV), minimum 1.
- TIMEOUT, 256, max ACCESS cycles waiting for pready before an error; 0 disables the timeout.

Ports:
- hclk  in  1  clock.
- hreset  in  1  reset.
- hsel_i  in  1  bridge select from AHB decoder.
- hready_i  in  1  AHB bus ready (previous transfer done).
- htrans_i  in  2  AHB transfer type.
- hwrite_i  in  1  write = 1.
- hsize_i  in  3  transfer size (0 = byte, 1 = half, 2 = word).
- haddr_i  in  ADDR_W  address.
- hwdata_i  in  32  write data.
- hready_o  out  1  bridge ready.
- hresp_o  out  1  0 = OKAY, 1 = ERROR.
- hrdata_o  out  32  read data.
- psel_o  out  NUM_SLV  one-hot APB select.
- penable_o  out  1  APB enable.
- pwrite_o  out  1  APB direction.
- paddr_o  out  ADDR_W  APB address.
- pwdata_o  out  32  APB write data.
- pstrb_o  out  4  byte strobes.
- prdata_i  in  NUM_SLV*32  per-slave read data, concatenated.
- pready_i  in  NUM_SLV  per-slave ready.
- pslverr_i  in  NUM_SLV  per-slave error.

Interface is one clock; reset is synchronous and active-high. Clock is hclk, reset is hreset.

Behaviour:
- Reset values:
  - state IDLE, hready_o = 1, hresp_o = 0, hrdata_o = 0.
  - psel_o = 0, penable_o = 0, pwrite_o = 0.
  - paddr_o = 0, pwdata_o = 0, pstrb_o = 0, timeout counter = 0.
- All outputs are registered. hrdata_o is registered; APB read data is never passed straight through to AHB.
- Accept condition: hsel_i & hready_i & htrans_i[1], sampled in IDLE or ERR2. BUSY and IDLE transfer types are ignored (OKAY, zero wait).
- On accept, register:
  - haddr_i into paddr_o, hwrite_i into pwrite_o.
  - slave index = haddr_i[SEL_LSB +: SEL_W].
  - pstrb_o: byte 0001<<a[1:0], half 0011<<{a[1],0}, word 1111; strobe is 0000 on reads.
  - hready_o drops to 0 the cycle after accept.
- State machine:
  - IDLE: on accept, go to DECERR if index >= NUM_SLV; else WDATA if write; else SETUP.
  - WDATA: latch hwdata_i into pwdata_o; go to SETUP.
  - SETUP: psel_o[idx] = 1, penable_o = 0; go to ACCESS.
  - ACCESS: psel_o[idx] = 1, penable_o = 1; count cycles.
    - On pready_i[idx] & !pslverr_i[idx]: register prdata_i slice into hrdata_o (reads only); go to IDLE with hready_o = 1.
    - On pready_i[idx] & pslverr_i[idx]: go to ERR1.
    - On count reaching TIMEOUT-1 without pready (TIMEOUT != 0): go to ERR1.
    - psel_o and penable_o fall on every ACCESS exit.
  - DECERR: no APB activity; go to ERR1.
  - ERR1: hready_o = 0, hresp_o = 1; go to ERR2.
  - ERR2: hready_o = 1, hresp_o = 1. An accept here is taken (next transfer pipelined behind the error); otherwise go to IDLE.
- Latency:
  - Zero-wait read: hready_o low for 2 cycles after accept (SETUP, ACCESS).
  - Zero-wait write: low for 3 cycles (WDATA, SETUP, ACCESS).
  - Each pready-low cycle adds 1.
- pwdata_o and paddr_o hold stable from SETUP until the next accept.
- hrdata_o holds its value until the next successful read.
- Only the indexed slave's pready/pslverr/prdata are observed; other slaves' inputs are ignored.
- hreset asserted mid-ACCESS: all outputs return to reset values on the next edge; the transfer is abandoned with no completion signalled.
- Timeout counter is cleared on entry to SETUP; it saturates rather than wraps.

Decomposition:
- Package ahb_apb_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ.
  - HRESP_OKAY/ERROR.
  - the state enum (IDLE, WDATA, SETUP, ACCESS, DECERR, ERR1, ERR2).
  - the HSIZE encodings.
- One sub-module: apb_slv_mux. It is combinational: given idx, it selects the prdata/pready/pslverr slice and generates the one-hot psel.

Test Plan:
- Read slave 2 at haddr 0x0000_2004, pready tied 1, prdata[2] = 0xDEAD_BEEF -> psel_o = 0x04 for 2 cycles (penable in 2nd); hrdata_o = 0xDEAD_BEEF, hresp_o = 0 on the hready_o rise 3 cycles after accept.
- Byte write 0xA5 at haddr 0x0000_1003 -> WDATA, SETUP, ACCESS; pstrb_o = 4'b1000, paddr_o = 0x0000_1003, pwdata_o = hwdata; slave 1 selected.
- Slave 3 holds pready low 4 cycles -> penable_o high 5 cycles; hready_o low 6 cycles for a read.
- pslverr with pready on slave 0 -> ERR1 (hready 0, hresp 1), ERR2 (hready 1, hresp 1); a back-to-back NONSEQ issued in ERR2 is accepted and completes OKAY.
- NUM_SLV = 6, access to index 7 -> no psel activity; two-cycle ERROR response.
- TIMEOUT = 8, pready never asserted -> penable_o high exactly 8 cycles, then ERROR. A separate run asserts hreset during ACCESS -> all outputs at reset values next cycle.
